// File: rtl/iram_prog_loader.sv
// ---------------------------------------------------------------------------
// iram_prog_loader
//   Byte-stream program loader for the instruction RAM. Each session starts
//   with a 3-byte little-endian word count. That many 128-bit words follow,
//   16 bytes per word with the least significant byte first. Each assembled
//   word is written to IRAM in a single one-cycle strobe, at consecutive
//   word addresses starting from BASE_ADDR.
//
//   Optional feature macro: IRAM_LOADER_CHKSUM_EN
//     defined   - one trailing checksum byte is accepted after the data. It is
//                 compared against the 8-bit modulo sum of all data bytes, and
//                 load_err reports a mismatch once DONE is reached.
//     undefined - there is no checksum byte, and load_err is tied low.
//
// Parameters
//   BASE_ADDR        word address of the first word written in a session
// Ports
//   pll_core_cpuclk  clock (rising edge)
//   pad_cpu_rst_b    asynchronous active-low reset
//   load_start       one-cycle request to start a session (IDLE/DONE only)
//   byte_valid       byte_data is valid
//   byte_data        stream byte
//   byte_ready       loader takes a byte this cycle (HDR/DATA/CHK)
//   prog_wen         IRAM write strobe, high only in WRITE
//   prog_waddr       IRAM word address (holds between writes)
//   prog_wdata       IRAM write data (holds between writes)
//   load_busy        a session is in progress
//   load_done        the session has completed; held until the next load_start
//   load_err         checksum mismatch
// ---------------------------------------------------------------------------

// One byte lane of the word assembly buffer. byte_nxt is the value the lane
// will hold after this edge, so the last byte of a word can be forwarded
// straight into the write-data register.
module iram_loader_lane #(
  parameter int VEC_W = 8
) (
  input  logic             pll_core_cpuclk,
  input  logic             pad_cpu_rst_b,
  input  logic             cap_en,
  input  logic [VEC_W-1:0] byte_in,
  output logic [VEC_W-1:0] byte_nxt
);

  logic [VEC_W-1:0] byte_q;

  assign byte_nxt = cap_en ? byte_in : byte_q;

  always_ff @(posedge pll_core_cpuclk or negedge pad_cpu_rst_b) begin
    if (!pad_cpu_rst_b) byte_q <= '0;
    else                byte_q <= byte_nxt;
  end

endmodule

module iram_prog_loader #(
  parameter logic [19:0] BASE_ADDR = 20'h00000
) (
  input  logic         pll_core_cpuclk,
  input  logic         pad_cpu_rst_b,
  input  logic         load_start,
  input  logic         byte_valid,
  input  logic [7:0]   byte_data,
  output logic         byte_ready,
  output logic         prog_wen,
  output logic [19:0]  prog_waddr,
  output logic [127:0] prog_wdata,
  output logic         load_busy,
  output logic         load_done,
  output logic         load_err
);

  localparam int NUM_LANES = 16;
  localparam int VEC_W     = 8;

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_HDR   = 3'd1;
  localparam logic [2:0] S_DATA  = 3'd2;
  localparam logic [2:0] S_WRITE = 3'd3;
`ifdef IRAM_LOADER_CHKSUM_EN
  localparam logic [2:0] S_CHK   = 3'd4;
`endif
  localparam logic [2:0] S_DONE  = 3'd5;

  // Where a session goes once the last word is written, or directly from
  // the header when the count is zero.
`ifdef IRAM_LOADER_CHKSUM_EN
  localparam logic [2:0] S_END = S_CHK;
`else
  localparam logic [2:0] S_END = S_DONE;
`endif

  logic [2:0]   state;
  logic [1:0]   hdr_idx;    // header byte number 0..2
  logic [3:0]   byte_idx;   // data byte number within the current word
  logic [19:0]  word_cnt;   // header accumulator, then words still to write
  logic [19:0]  addr;       // address of the word being assembled
  logic [19:0]  waddr_q;
  logic [127:0] wdata_q;
`ifdef IRAM_LOADER_CHKSUM_EN
  logic [7:0]   sum;
  logic         err_q;
`endif

  logic         byte_xfer;
  logic         data_xfer;
  logic [19:0]  hdr_count;

  logic [NUM_LANES-1:0]            lane_cap;
  logic [NUM_LANES-1:0][VEC_W-1:0] lane_nxt;

  // byte_ready is decoded from state alone, with no path from byte_valid.
  assign byte_ready = (state == S_HDR) || (state == S_DATA)
`ifdef IRAM_LOADER_CHKSUM_EN
                   || (state == S_CHK)
`endif
                   ;
  assign byte_xfer  = byte_valid && byte_ready;
  assign data_xfer  = byte_xfer && (state == S_DATA);

  // Count as it will be once the third header byte lands. Header bits
  // [23:20] are dropped here.
  assign hdr_count  = {byte_data[3:0], word_cnt[15:0]};

  assign prog_wen   = (state == S_WRITE);
  assign prog_waddr = waddr_q;
  assign prog_wdata = wdata_q;
  assign load_busy  = byte_ready || (state == S_WRITE);
  assign load_done  = (state == S_DONE);
`ifdef IRAM_LOADER_CHKSUM_EN
  assign load_err   = err_q;
`else
  assign load_err   = 1'b0;
`endif

  // Word assembly buffer: lane k captures data byte k of the current word.
  for (genvar k = 0; k < NUM_LANES; k++) begin : g_lane
    assign lane_cap[k] = data_xfer && (byte_idx == 4'(k));

    iram_loader_lane #(.VEC_W(VEC_W)) u_lane (
      .pll_core_cpuclk (pll_core_cpuclk),
      .pad_cpu_rst_b   (pad_cpu_rst_b),
      .cap_en          (lane_cap[k]),
      .byte_in         (byte_data),
      .byte_nxt        (lane_nxt[k])
    );
  end

  always_ff @(posedge pll_core_cpuclk or negedge pad_cpu_rst_b) begin
    if (!pad_cpu_rst_b) begin
      state    <= S_IDLE;
      hdr_idx  <= '0;
      byte_idx <= '0;
      word_cnt <= '0;
      addr     <= '0;
      waddr_q  <= '0;
      wdata_q  <= '0;
`ifdef IRAM_LOADER_CHKSUM_EN
      sum      <= '0;
      err_q    <= 1'b0;
`endif
    end else begin
      case (state)
        S_IDLE, S_DONE: begin
          if (load_start) begin
            state    <= S_HDR;
            hdr_idx  <= '0;
            byte_idx <= '0;
            word_cnt <= '0;
            addr     <= BASE_ADDR;
`ifdef IRAM_LOADER_CHKSUM_EN
            sum      <= '0;
            err_q    <= 1'b0;
`endif
          end
        end

        S_HDR: begin
          if (byte_xfer) begin
            hdr_idx <= hdr_idx + 2'd1;
            if (hdr_idx == 2'd0) begin
              word_cnt[7:0] <= byte_data;
            end else if (hdr_idx == 2'd1) begin
              word_cnt[15:8] <= byte_data;
            end else begin
              word_cnt <= hdr_count;
              state    <= (hdr_count == 20'd0) ? S_END : S_DATA;
            end
          end
        end

        S_DATA: begin
          if (byte_xfer) begin
            byte_idx <= byte_idx + 4'd1;   // wraps to 0 for the next word
`ifdef IRAM_LOADER_CHKSUM_EN
            sum      <= sum + byte_data;
`endif
            // The last byte goes into the write register through the lane's
            // forwarded value, so WRITE follows without an extra cycle.
            if (byte_idx == 4'd15) begin
              state   <= S_WRITE;
              waddr_q <= addr;
              wdata_q <= lane_nxt;
            end
          end
        end

        S_WRITE: begin
          addr     <= addr + 20'd1;
          word_cnt <= word_cnt - 20'd1;
          state    <= (word_cnt == 20'd1) ? S_END : S_DATA;
        end

`ifdef IRAM_LOADER_CHKSUM_EN
        S_CHK: begin
          if (byte_xfer) begin
            err_q <= (byte_data != sum);
            state <= S_DONE;
          end
        end
`endif

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_iram_prog_loader.sv
// ---------------------------------------------------------------------------
// tb_iram_prog_loader
//   Directed bench for iram_prog_loader. It drives a table of load sessions
//   into two instances: one with the default BASE_ADDR and one with
//   BASE_ADDR = 20'hFFFFF, which share all of their inputs. It also runs
//   hand-written sequences for reset and for a reset in the middle of a
//   session. The bench follows IRAM_LOADER_CHKSUM_EN the same way the design
//   does.
// ---------------------------------------------------------------------------
module tb_iram_prog_loader;

`ifdef IRAM_LOADER_CHKSUM_EN
  localparam bit CHK = 1'b1;
`else
  localparam bit CHK = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         load_start = 1'b0;
  logic         byte_valid = 1'b0;
  logic [7:0]   byte_data = 8'h00;

  logic         byte_ready, prog_wen, load_busy, load_done, load_err;
  logic [19:0]  prog_waddr;
  logic [127:0] prog_wdata;
  logic         h_byte_ready, h_prog_wen, h_load_busy, h_load_done, h_load_err;
  logic [19:0]  h_prog_waddr;
  logic [127:0] h_prog_wdata;

  iram_prog_loader dut (
    .pll_core_cpuclk (clk),
    .pad_cpu_rst_b   (rst_n),
    .load_start      (load_start),
    .byte_valid      (byte_valid),
    .byte_data       (byte_data),
    .byte_ready      (byte_ready),
    .prog_wen        (prog_wen),
    .prog_waddr      (prog_waddr),
    .prog_wdata      (prog_wdata),
    .load_busy       (load_busy),
    .load_done       (load_done),
    .load_err        (load_err)
  );

  iram_prog_loader #(.BASE_ADDR(20'hFFFFF)) dut_hi (
    .pll_core_cpuclk (clk),
    .pad_cpu_rst_b   (rst_n),
    .load_start      (load_start),
    .byte_valid      (byte_valid),
    .byte_data       (byte_data),
    .byte_ready      (h_byte_ready),
    .prog_wen        (h_prog_wen),
    .prog_waddr      (h_prog_waddr),
    .prog_wdata      (h_prog_wdata),
    .load_busy       (h_load_busy),
    .load_done       (h_load_done),
    .load_err        (h_load_err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  typedef struct {
    logic [19:0]  addr;
    logic [127:0] data;
    int           t;
  } wr_t;

  wr_t wq[$];
  wr_t hq[$];

  always @(posedge clk) cyc++;

  // Write strobes are captured on the falling edge, away from the active edge.
  always @(negedge clk) begin
    if (prog_wen)   wq.push_back('{prog_waddr, prog_wdata, cyc});
    if (h_prog_wen) hq.push_back('{h_prog_waddr, h_prog_wdata, cyc});
  end

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic [23:0]  hdr;
    logic [19:0]  nwords;   // expected word count after dropping bits [23:20]
    logic [7:0]   start;    // first data byte; following bytes increment
    bit           fixed;    // all data bytes equal start
    bit           gaps;     // one idle byte_valid cycle before every byte
    bit           poke;     // pulse load_start in the middle of the data
    bit           chk_ovr;  // send chk_val rather than the true checksum
    logic [7:0]   chk_val;
    logic [127:0] exp_w0;   // hand-computed first word
    bit           exp_err;  // expected load_err when the checksum is enabled
  } vec_t;

  vec_t vecs[6];

  function automatic logic [7:0] dbyte(input vec_t v, input int i);
    return v.fixed ? v.start : 8'(int'(v.start) + i);
  endfunction

  // Drive byte b, then return on the falling edge just before the rising
  // edge that accepts it.
  task automatic send_byte(input logic [7:0] b, input bit gap);
    int tries = 0;
    if (gap) begin
      @(negedge clk);
      byte_valid = 1'b0;
    end
    @(negedge clk);
    byte_valid = 1'b1;
    byte_data  = b;
    while (!byte_ready && tries < 100) begin
      @(negedge clk);
      tries++;
    end
    if (!byte_ready) begin
      checks++;
      errors++;
      $display("FAIL byte_ready_timeout: got 0 expected 1");
    end
  endtask

  task automatic pulse_start();
    @(negedge clk);
    byte_valid = 1'b0;
    load_start = 1'b1;
    @(negedge clk);
    load_start = 1'b0;
  endtask

  task automatic run_vec(input vec_t v, input string tag);
    logic [7:0]   sum;
    logic [127:0] w;
    int           t;
    int           n;
    wq.delete();
    hq.delete();
    sum = 8'h00;
    pulse_start();
    chk({tag, " busy_at_start"}, load_busy, 1);
    chk({tag, " err_cleared"}, load_err, 0);
    chk({tag, " done_cleared"}, load_done, 0);
    for (int i = 0; i < 3; i++) send_byte(v.hdr[8*i +: 8], v.gaps);
    n = int'(v.nwords) * 16;
    for (int i = 0; i < n; i++) begin
      send_byte(dbyte(v, i), v.gaps);
      sum = sum + dbyte(v, i);
      if (v.poke && i == 5) begin
        @(negedge clk);
        byte_valid = 1'b0;
        load_start = 1'b1;
        @(negedge clk);
        load_start = 1'b0;
      end
    end
    if (CHK) send_byte(v.chk_ovr ? v.chk_val : sum, v.gaps);
    @(negedge clk);
    byte_valid = 1'b0;
    t = 0;
    while (!load_done && t < 100) begin
      @(negedge clk);
      t++;
    end
    chk({tag, " done"}, load_done, 1);
    chk({tag, " busy_end"}, load_busy, 0);
    chk({tag, " ready_end"}, byte_ready, 0);
    chk({tag, " err"}, load_err, v.exp_err & CHK);
    repeat (3) @(negedge clk);
    chk({tag, " done_hold"}, load_done, 1);
    chk({tag, " nwrites"}, wq.size(), v.nwords);
    chk({tag, " hi_nwrites"}, hq.size(), v.nwords);
    for (int i = 0; i < wq.size() && i < int'(v.nwords); i++) begin
      for (int k = 0; k < 16; k++) w[8*k +: 8] = dbyte(v, 16*i + k);
      chk({tag, $sformatf(" waddr%0d", i)}, wq[i].addr, 20'(i));
      chk({tag, $sformatf(" wdata%0d", i)}, wq[i].data, w);
      if (i == 0) chk({tag, " wdata0_hand"}, wq[0].data, v.exp_w0);
      if (i > 0 && !v.gaps && !v.poke)
        chk({tag, $sformatf(" word_period%0d", i)}, wq[i].t - wq[i-1].t, 17);
      if (i < hq.size()) begin
        chk({tag, $sformatf(" hi_waddr%0d", i)}, hq[i].addr, 20'(20'hFFFFF + 20'(i)));
        chk({tag, $sformatf(" hi_wdata%0d", i)}, hq[i].data, w);
      end
    end
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, " ready"}, byte_ready, 0);
    chk({tag, " wen"}, prog_wen, 0);
    chk({tag, " waddr"}, prog_waddr, 0);
    chk({tag, " wdata"}, prog_wdata, 0);
    chk({tag, " busy"}, load_busy, 0);
    chk({tag, " done"}, load_done, 0);
    chk({tag, " err"}, load_err, 0);
    chk({tag, " hi_waddr"}, h_prog_waddr, 0);
    chk({tag, " hi_wdata"}, h_prog_wdata, 0);
  endtask

  initial begin
    vecs[0] = '{24'h000001, 20'd1, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00,
                128'h0F0E0D0C0B0A09080706050403020100, 1'b0};
    vecs[1] = '{24'h000003, 20'd3, 8'h20, 1'b0, 1'b1, 1'b1, 1'b0, 8'h00,
                128'h2F2E2D2C2B2A29282726252423222120, 1'b0};
    vecs[2] = '{24'h000000, 20'd0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00,
                128'h0, 1'b0};
    vecs[3] = '{24'hF00002, 20'd2, 8'hF8, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00,
                128'h0706050403020100FFFEFDFCFBFAF9F8, 1'b0};
    vecs[4] = '{24'h000001, 20'd1, 8'h11, 1'b1, 1'b0, 1'b0, 1'b1, 8'h11,
                128'h11111111111111111111111111111111, 1'b1};
    vecs[5] = '{24'h000001, 20'd1, 8'h11, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00,
                128'h11111111111111111111111111111111, 1'b0};

    // Reset state
    repeat (2) @(negedge clk);
    chk_reset_outputs("reset");
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    chk_reset_outputs("idle");

    for (int v = 0; v < 6; v++) run_vec(vecs[v], $sformatf("vec%0d", v));

    // Reset after 8 data bytes of word 0: the partial word must be dropped.
    wq.delete();
    hq.delete();
    pulse_start();
    for (int i = 0; i < 3; i++) send_byte(vecs[0].hdr[8*i +: 8], 1'b0);
    for (int i = 0; i < 8; i++) send_byte(8'hA0 + 8'(i), 1'b0);
    @(negedge clk);
    rst_n = 1'b0;
    byte_valid = 1'b0;
    #1;
    chk_reset_outputs("midrst");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (20) @(negedge clk);
    chk("midrst nwrites", wq.size(), 0);
    chk("midrst idle_busy", load_busy, 0);
    chk("midrst idle_wen", prog_wen, 0);
    run_vec(vecs[0], "postrst");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
